// File: rtl/micro_pkg.sv
// Shared microcontroller definitions: opcode map, sequencer state encodings
// and next-PC source encodings used by instr_sequencer and control_unit.
package micro_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-handshake wait counter with timeout compare; saturates at the
// timeout value so it can never wrap back to zero while a request is stuck.
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB, turns the
// static decode strobes into per-stage enables and halts on illegal ops or bus timeouts.
module instr_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       dec_reg_write,
  input  logic       dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_branch,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write_en,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  import micro_pkg::*;

  seq_state_t st;
  pc_sel_t    sel;
  logic       tmr_en;
  logic       tmr_clr;
  logic       tmr_expired;

  function automatic pc_sel_t pick_pc_sel(input logic [6:0] op,
                                          input logic       br,
                                          input logic       taken);
    if (op == OP_JAL) begin
      return PC_JAL;
    end else if (op == OP_JALR) begin
      return PC_JALR;
    end else if (br && taken) begin
      return PC_BRANCH;
    end
    return PC_PLUS4;
  endfunction

  // The counter only runs while a memory request is outstanding; any other
  // cycle (including the one that leaves FETCH/MEM) zeroes it, so every state
  // is entered with a clean count.
  assign tmr_en  = ((st == ST_FETCH) || (st == ST_MEM)) && !mem_ready;
  assign tmr_clr = !tmr_en || tmr_expired;

  seq_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (run) st <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            st <= ST_DECODE;
          end else if (tmr_expired) begin
            st      <= ST_HALT;
            bus_err <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (opcode_legal(opcode)) begin
            st <= ST_EXECUTE;
          end else begin
            st      <= ST_HALT;
            illegal <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          st <= (dec_mem_read || dec_mem_write) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          // A write strobe wins over a read strobe: such instructions retire here.
          if (mem_ready) begin
            if (dec_mem_write) st <= run ? ST_FETCH : ST_IDLE;
            else               st <= ST_WB;
          end else if (tmr_expired) begin
            st      <= ST_HALT;
            bus_err <= 1'b1;
          end
        end
        ST_WB: begin
          st <= run ? ST_FETCH : ST_IDLE;
        end
        ST_HALT: begin
          st <= ST_HALT;
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;
    retire       = 1'b0;
    sel          = PC_PLUS4;
    case (st)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = mem_ready;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (mem_ready && dec_mem_write) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        reg_write_en = dec_reg_write;
        pc_write     = 1'b1;
        retire       = 1'b1;
        sel          = pick_pc_sel(opcode, dec_branch, branch_taken);
      end
      default: begin
      end
    endcase
  end

  assign pc_sel = sel;
  assign state  = st;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed instructions push expected
// retire records / output snapshots; a negedge monitor pops and compares them.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [6:0] opcode;
  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, branch_taken;
  logic       mem_ready;
  logic       imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_write, retire;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic       illegal, bus_err;

  always #5 clk = ~clk;

  instr_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_branch(dec_branch),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_write(pc_write),
    .pc_sel(pc_sel), .retire(retire), .state(state),
    .illegal(illegal), .bus_err(bus_err)
  );

  typedef struct packed {
    logic       rwe;
    logic       pcw;
    logic [1:0] sel;
    logic       dreq;
    logic       dwe;
    logic [3:0] mcyc;
    logic [7:0] lat;
  } ret_t;

  localparam logic [13:0] SNAP_IDLE = 14'd0;

  ret_t        ret_q[$];
  string       ret_name_q[$];
  logic [13:0] snap_q[$];
  string       snap_name_q[$];
  logic        snap_req = 1'b0;
  logic        done = 1'b0;
  int          fetch_wait = 0;
  int          mem_wait = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [13:0] mk(input logic [2:0] st, input logic ill, be, imem, irl,
                                     dreq, dwe, rwe, pcw, input logic [1:0] sel,
                                     input logic ret);
    return {st, ill, be, imem, irl, dreq, dwe, rwe, pcw, sel, ret};
  endfunction

  function automatic ret_t mr(input logic rwe, pcw, input logic [1:0] sel,
                              input logic dreq, dwe, input int mcyc, lat);
    return {rwe, pcw, sel, dreq, dwe, 4'(mcyc), 8'(lat)};
  endfunction

  // Memory responder: asserts mem_ready after the programmed number of wait cycles.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (imem_req || dmem_req) begin
      mem_ready = (wcnt >= (imem_req ? fetch_wait : mem_wait));
      wcnt = mem_ready ? 0 : wcnt + 1;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: tracks FETCH-to-retire latency and MEM cycles, compares on retire/snapshot.
  int          lat = 0;
  int          mcyc = 0;
  logic [2:0]  prev_st = 3'd0;
  ret_t        ract, rexp;
  logic [13:0] sact, sexp;
  string       nm;
  always @(negedge clk) begin
    if (state == 3'd1 && prev_st != 3'd1) begin
      lat = 1;
      mcyc = 0;
    end else begin
      lat++;
    end
    if (dmem_req === 1'b1) mcyc++;
    prev_st = state;
    if (retire !== 1'b0) begin
      ract = {reg_write_en, pc_write, pc_sel, dmem_req, dmem_we, 4'(mcyc), 8'(lat)};
      n_vec++;
      if (ret_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retire: got %h required no retire", ract);
      end else begin
        rexp = ret_q.pop_front();
        nm = ret_name_q.pop_front();
        if (ract !== rexp) begin
          n_err++;
          $display("FAIL %s: got %h required %h (rwe,pcw,sel,dreq,dwe,mcyc,lat)", nm, ract, rexp);
        end
      end
    end
    if (snap_req) begin
      sact = {state, illegal, bus_err, imem_req, ir_load, dmem_req, dmem_we,
              reg_write_en, pc_write, pc_sel, retire};
      sexp = snap_q.pop_front();
      nm = snap_name_q.pop_front();
      n_vec++;
      if (sact !== sexp) begin
        n_err++;
        $display("FAIL %s: got %b required %b (state,ill,berr,imem,irl,dreq,dwe,rwe,pcw,sel,ret)",
                 nm, sact, sexp);
      end
    end
    if (done) begin
      while (ret_q.size() > 0) begin
        n_vec++;
        n_err++;
        rexp = ret_q.pop_front();
        nm = ret_name_q.pop_front();
        $display("FAIL %s: got no retire required %h", nm, rexp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string name, input logic [13:0] e);
    snap_q.push_back(e);
    snap_name_q.push_back(name);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  // Bounded wait; on expiry a snapshot expecting the target state records the failure.
  task automatic wait_state(input logic [2:0] tgt, input int limit, input string name);
    int i = 0;
    while (state !== tgt && i < limit) begin
      step();
      i++;
    end
    if (state !== tgt) snap({name, "_timeout"}, mk(tgt, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
  endtask

  task automatic set_dec(input logic [6:0] op, input logic rw, rd, wr, br, bt);
    opcode = op;
    dec_reg_write = rw;
    dec_mem_read = rd;
    dec_mem_write = wr;
    dec_branch = br;
    branch_taken = bt;
  endtask

  task automatic exec(input string name, input logic [6:0] op, input logic rw, rd, wr, br, bt,
                      input int fw, mwt, input ret_t e);
    set_dec(op, rw, rd, wr, br, bt);
    fetch_wait = fw;
    mem_wait = mwt;
    ret_q.push_back(e);
    ret_name_q.push_back(name);
    run = 1'b1;
    step();
    run = 1'b0;
    wait_state(3'd0, 60, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    set_dec(7'b0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    snap("reset_idle", SNAP_IDLE);

    exec("rtype",        7'b0110011, 1, 0, 0, 0, 0, 0, 0, mr(1, 1, 2'b00, 0, 0, 0, 4));
    exec("load_wait3",   7'b0000011, 1, 1, 0, 0, 0, 0, 3, mr(1, 1, 2'b00, 0, 0, 4, 8));
    exec("store",        7'b0100011, 0, 0, 1, 0, 0, 0, 0, mr(0, 1, 2'b00, 1, 1, 1, 4));
    exec("store_wait2",  7'b0100011, 0, 0, 1, 0, 0, 0, 2, mr(0, 1, 2'b00, 1, 1, 3, 6));
    exec("branch_taken", 7'b1100011, 0, 0, 0, 1, 1, 0, 0, mr(0, 1, 2'b01, 0, 0, 0, 4));
    exec("branch_not",   7'b1100011, 0, 0, 0, 1, 0, 0, 0, mr(0, 1, 2'b00, 0, 0, 0, 4));
    exec("jal",          7'b1101111, 1, 0, 0, 1, 1, 0, 0, mr(1, 1, 2'b10, 0, 0, 0, 4));
    exec("jalr",         7'b1100111, 1, 0, 0, 0, 0, 0, 0, mr(1, 1, 2'b11, 0, 0, 0, 4));
    exec("itype_fwait2", 7'b0010011, 1, 0, 0, 0, 0, 2, 0, mr(1, 1, 2'b00, 0, 0, 0, 6));
    exec("lui",          7'b0110111, 1, 0, 0, 0, 0, 0, 0, mr(1, 1, 2'b00, 0, 0, 0, 4));
    exec("auipc",        7'b0010111, 1, 0, 0, 0, 0, 0, 0, mr(1, 1, 2'b00, 0, 0, 0, 4));
    exec("load_and_wr",  7'b0000011, 1, 1, 1, 0, 0, 0, 0, mr(0, 1, 2'b00, 1, 1, 1, 4));
    fetch_wait = 0;
    mem_wait = 0;

    // run held high, then dropped while the instruction is in EXECUTE
    set_dec(7'b0110011, 1, 0, 0, 0, 0);
    ret_q.push_back(mr(1, 1, 2'b00, 0, 0, 0, 4));
    ret_name_q.push_back("run_drop_exec");
    run = 1'b1;
    wait_state(3'd3, 10, "reach_execute");
    run = 1'b0;
    wait_state(3'd0, 10, "run_drop_idle");
    snap("idle_no_fetch_a", SNAP_IDLE);
    snap("idle_no_fetch_b", SNAP_IDLE);

    // reset while in DECODE aborts with no strobes on the following cycle
    run = 1'b1;
    step();
    run = 1'b0;
    wait_state(3'd2, 10, "reach_decode");
    rst = 1'b1;
    step();
    rst = 1'b0;
    snap("rst_abort", SNAP_IDLE);

    // illegal opcode 0000000
    set_dec(7'b0000000, 1, 0, 0, 0, 0);
    run = 1'b1;
    step();
    snap("illegal_fetch",  mk(3'd1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0));
    snap("illegal_decode", mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    snap("illegal_halt",   mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    for (int k = 0; k < 20; k++) snap("halt_hold", mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    run = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    snap("rst_clears_illegal", SNAP_IDLE);

    // instruction fetch timeout
    set_dec(7'b0110011, 1, 0, 0, 0, 0);
    fetch_wait = 100;
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (14) step();
    snap("fetch_wait_15",  mk(3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    snap("fetch_wait_16",  mk(3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    snap("fetch_timeout",  mk(3'd6, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch_wait = 0;
    snap("rst_clears_berr", SNAP_IDLE);

    // data memory timeout on a load
    set_dec(7'b0000011, 1, 1, 0, 0, 0);
    mem_wait = 100;
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (18) step();
    snap("mem_wait_16",   mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    snap("mem_timeout",   mk(3'd6, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_wait = 0;
    snap("final_idle", SNAP_IDLE);

    done = 1'b1;
    repeat (3) step();
    $display("FAIL monitor_end: got no summary required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
